// File: rtl/dec_scan_sequencer.sv
// Scan controller for a 3-to-8 decoder: steps sel through the set bits of a
// latched mask, holding en for a dwell time with optional blanking between channels.
module dec_scan_sequencer #(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned BLANK   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               ch_strobe,
    output logic               done
);

    localparam int unsigned BLANK_W = $clog2(BLANK + 1);
    localparam int unsigned CNT_W   = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 32'd1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic [2:0]         nxt_q, nxt_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               mode_q, mode_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               ch_strobe_q, ch_strobe_d;
    logic               done_q, done_d;
    logic               enter_act, pass_done;

    function automatic logic [2:0] low_idx(input logic [7:0] m);
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) low_idx = 3'(i);
        end
    endfunction

    // {found, index} of the lowest set bit strictly above s
    function automatic logic [3:0] above_idx(input logic [7:0] m, input logic [2:0] s);
        above_idx = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(s))) above_idx = {1'b1, 3'(i)};
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            sel_q       <= 3'd0;
            nxt_q       <= 3'd0;
            mask_q      <= 8'd0;
            dwell_q     <= '0;
            mode_q      <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            ch_strobe_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            nxt_q       <= nxt_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            mode_q      <= mode_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            ch_strobe_q <= ch_strobe_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        logic [3:0]         up;
        logic [2:0]         nxt;
        logic [DWELL_W-1:0] dwell_eff;
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        nxt_d     = nxt_q;
        mask_d    = mask_q;
        dwell_d   = dwell_q;
        mode_d    = mode_q;
        enter_act = 1'b0;
        pass_done = 1'b0;
        up        = above_idx(mask_q, sel_q);
        nxt       = up[3] ? up[2:0] : low_idx(mask_q);
        dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
        unique case (state_q)
            S_IDLE: begin
                sel_d = 3'd0;
                if (start && !stop && (mask != 8'd0)) begin
                    mask_d    = mask;
                    dwell_d   = dwell_eff;
                    mode_d    = mode;
                    sel_d     = low_idx(mask);
                    cnt_d     = CNT_W'(dwell_eff - DWELL_W'(1));
                    state_d   = S_ACTIVE;
                    enter_act = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    sel_d   = 3'd0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!up[3] && !mode_q) begin
                    state_d   = S_IDLE;
                    sel_d     = 3'd0;
                    pass_done = 1'b1;
                end else if (BLANK > 0) begin
                    state_d = S_BLANK;
                    cnt_d   = BLANK_LAST;
                    nxt_d   = nxt;
                end else begin
                    sel_d     = nxt;
                    cnt_d     = CNT_W'(dwell_q - DWELL_W'(1));
                    enter_act = 1'b1;
                end
            end
            S_BLANK: begin
                if (stop) begin
                    state_d = S_IDLE;
                    sel_d   = 3'd0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d   = S_ACTIVE;
                    sel_d     = nxt_q;
                    cnt_d     = CNT_W'(dwell_q - DWELL_W'(1));
                    enter_act = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        en_d        = (state_d == S_ACTIVE);
        busy_d      = (state_d != S_IDLE);
        ch_strobe_d = enter_act;
        done_d      = pass_done;
    end

    assign sel       = sel_q;
    assign en        = en_q;
    assign busy      = busy_q;
    assign ch_strobe = ch_strobe_q;
    assign done      = done_q;

endmodule
